// File: rtl/flp_pkg.sv
// flp_pkg: FP32 width constants shared by the significand normaliser and its helpers.
`default_nettype none

package flp_pkg;

  localparam int INWIDTH = 32;
  localparam int EWIDTH  = 8;
  localparam int SWIDTH  = 23;
  localparam int RSWIDTH = 2;
  localparam int OWIDTH  = SWIDTH + 1 + RSWIDTH;
  localparam int EXDWIDTH = EWIDTH + 2;

  // Bits needed to index any position of an n-bit word (minimum 1).
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flp_lzd.sv
// flp_lzd: combinational leading-one detector with an all-zero flag.
`default_nettype none

module flp_lzd
  import flp_pkg::*;
#(
  parameter int INWIDTH = flp_pkg::INWIDTH,
  parameter int PWIDTH  = pos_width(INWIDTH)
) (
  input  logic [INWIDTH-1:0] sg,
  output logic [PWIDTH-1:0]  pos,
  output logic               zero
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    pos = '0;
    for (int i = 0; i < INWIDTH; i++) begin
      if (sg[i]) begin
        pos = PWIDTH'(i);
      end
    end
  end

  assign zero = ~|sg;

endmodule

`default_nettype wire

// File: rtl/flp_normalizer.sv
// flp_normalizer: shifts the leading one of a raw significand to the hidden-bit position, one register stage.
// Optional FLP_NORM_STICKY_EN folds bits lost on right shifts into o_sg[0].
`default_nettype none

module flp_normalizer
  import flp_pkg::*;
#(
  parameter int INWIDTH = flp_pkg::INWIDTH,
  parameter int EWIDTH  = flp_pkg::EWIDTH,
  parameter int SWIDTH  = flp_pkg::SWIDTH,
  parameter int RSWIDTH = flp_pkg::RSWIDTH,
  parameter int OWIDTH  = SWIDTH + 1 + RSWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [INWIDTH-1:0]  i_sg,
  output logic                o_valid,
  output logic [OWIDTH-1:0]   o_sg,
  output logic [EWIDTH+1:0]   o_exd,
  output logic                o_zero
);

  localparam int PWIDTH = pos_width(INWIDTH);
  localparam int HIDDEN = OWIDTH - 1;

  logic [PWIDTH-1:0]  lead_pos;
  logic               in_zero;
  int                 delta;
  int                 rshift_amt;
  int                 lshift_amt;
  logic [OWIDTH-1:0]  sg_right;
  logic [OWIDTH-1:0]  sg_left;
  logic               sticky;
  logic [OWIDTH-1:0]  sg_next;
  logic [EWIDTH+1:0]  exd_next;

  flp_lzd #(
    .INWIDTH (INWIDTH),
    .PWIDTH  (PWIDTH)
  ) u_lzd (
    .sg   (i_sg),
    .pos  (lead_pos),
    .zero (in_zero)
  );

  always_comb begin
    delta      = int'(lead_pos) - HIDDEN;
    rshift_amt = (delta > 0) ? delta : 0;
    lshift_amt = (delta < 0) ? -delta : 0;
  end

  assign sg_right = OWIDTH'(i_sg >> rshift_amt);
  assign sg_left  = OWIDTH'(i_sg << lshift_amt);

  // Everything below the shift amount is what a right shift throws away.
  assign sticky = |(i_sg & ~({INWIDTH{1'b1}} << rshift_amt));

  always_comb begin
    sg_next  = '0;
    exd_next = '0;
    if (!in_zero) begin
      exd_next = (EWIDTH + 2)'(delta);
      if (delta > 0) begin
        sg_next = sg_right;
`ifdef FLP_NORM_STICKY_EN
        sg_next[0] = sg_right[0] | sticky;
`endif
      end else begin
        sg_next = sg_left;
      end
    end
  end

`ifndef FLP_NORM_STICKY_EN
  logic unused_sticky;
  assign unused_sticky = sticky;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sg    <= '0;
      o_exd   <= '0;
      o_zero  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_sg   <= sg_next;
        o_exd  <= exd_next;
        o_zero <= in_zero;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flp_normalizer.sv
// tb_flp_normalizer: directed and random vectors checked against an arithmetic model every cycle.
`default_nettype none

module tb_flp_normalizer;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_sg;
  logic        o_valid;
  logic [25:0] o_sg;
  logic [9:0]  o_exd;
  logic        o_zero;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 0;

  flp_normalizer dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_sg    (i_sg),
    .o_valid (o_valid),
    .o_sg    (o_sg),
    .o_exd   (o_exd),
    .o_zero  (o_zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

`ifdef FLP_NORM_STICKY_EN
  localparam bit STICKY = 1;
`else
  localparam bit STICKY = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic statement of the normalisation rule.
  function automatic void model(input logic [31:0] x, output logic [25:0] sg,
                                output logic [9:0] exd, output logic z);
    int p;
    int d;
    longint v;
    longint scale;
    p = -1;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    sg = '0; exd = '0; z = 0;
    if (p < 0) begin
      z = 1;
    end else begin
      d = p - 25;
      v = longint'(x);
      exd = 10'(d);
      if (d > 0) begin
        scale = longint'(1) << d;
        sg = 26'(v / scale);
        if (STICKY && (v % scale) != 0) sg[0] = 1'b1;
      end else begin
        scale = longint'(1) << (-d);
        sg = 26'(v * scale);
      end
    end
  endfunction

  // Expected output registers, advanced from the inputs seen at each rising edge.
  logic        e_valid = 0;
  logic [25:0] e_sg    = 0;
  logic [9:0]  e_exd   = 0;
  logic        e_zero  = 0;

  initial begin
    logic [25:0] s;
    logic [9:0]  e;
    logic        z;
    forever begin
      @(posedge clk);
      if (rst) begin
        e_valid = 0; e_sg = 0; e_exd = 0; e_zero = 0;
      end else begin
        e_valid = i_valid;
        if (i_valid) begin
          model(i_sg, s, e, z);
          e_sg = s; e_exd = e; e_zero = z;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        chk("cyc_valid", 32'(o_valid), 32'(e_valid));
        chk("cyc_sg",    32'(o_sg),    32'(e_sg));
        chk("cyc_exd",   32'(o_exd),   32'(e_exd));
        chk("cyc_zero",  32'(o_zero),  32'(e_zero));
      end
    end
  end

  typedef struct {
    logic [31:0] in;
    logic [25:0] sg;
    logic [9:0]  exd;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  task automatic drive(input logic v, input logic [31:0] x);
    @(negedge clk);
    i_valid = v;
    i_sg    = x;
  endtask

  initial begin
    logic [25:0] sticky_sg;
    sticky_sg = STICKY ? 26'h200_0001 : 26'h200_0000;
    vecs[0] = '{32'h0200_0000, 26'h200_0000, 10'h000, 1'b0};
    vecs[1] = '{32'h0800_0000, 26'h200_0000, 10'h002, 1'b0};
    vecs[2] = '{32'h0080_0000, 26'h200_0000, 10'h3FE, 1'b0};
    vecs[3] = '{32'h0000_0001, 26'h200_0000, 10'h3E7, 1'b0};
    vecs[4] = '{32'h0800_0001, sticky_sg,    10'h002, 1'b0};
    vecs[5] = '{32'h0800_0002, sticky_sg,    10'h002, 1'b0};
    vecs[6] = '{32'h0000_0000, 26'h000_0000, 10'h000, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 26'h3FF_FFFF, 10'h006, 1'b0};

    rst = 1; i_valid = 1; i_sg = 32'h0800_0000;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_sg",    32'(o_sg),    32'h0);
    chk("rst_exd",   32'(o_exd),   32'h0);
    chk("rst_zero",  32'(o_zero),  32'h0);

    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, vecs[k].in);
      @(posedge clk);
      #2;
      chk($sformatf("dir%0d_valid", k), 32'(o_valid), 32'h1);
      chk($sformatf("dir%0d_sg", k),    32'(o_sg),    32'(vecs[k].sg));
      chk($sformatf("dir%0d_exd", k),   32'(o_exd),   32'(vecs[k].exd));
      chk($sformatf("dir%0d_zero", k),  32'(o_zero),  32'(vecs[k].z));
    end

    // Idle cycles with changing data must leave the last result in place.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0000_0010 << k);
      @(posedge clk);
      #2;
      chk("hold_valid", 32'(o_valid), 32'h0);
      chk("hold_sg",    32'(o_sg),    32'h3FF_FFFF);
      chk("hold_exd",   32'(o_exd),   32'h006);
    end

    for (int k = 0; k < 300; k++) begin
      logic [31:0] x;
      x = $urandom() >> $urandom_range(0, 32);
      if ($urandom_range(0, 15) == 0) x = 32'h0;
      drive(($urandom_range(0, 3) != 0), x);
      if (k == 150) rst = 1;
      if (k == 151) rst = 0;
    end

    drive(1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
